// File: rtl/rob_wfi_snpt_ctrl.sv
// ROB-side WFI sleep controller and circular rename-snapshot tracker.
// Gates commit while a WFI drains and sleeps, and selects restore points for redirects.
module rob_wfi_snpt_ctrl #(
    parameter int SNPT_NUM = 4,
    parameter int ROBIDX_W = 8,
    parameter int TMO_W = 16,
    parameter logic [TMO_W-1:0] WFI_TMO = 16'hFFFF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        io_wfi_req,
    input  logic                        io_wfi_enable,
    input  logic                        io_wfi_safeFromMem,
    input  logic                        io_wfi_safeFromFrontend,
    input  logic                        io_csr_intrBitSet,
    input  logic                        io_csr_wfiEvent,
    input  logic                        io_csr_criticalErrorState,
    input  logic                        io_snpt_enq,
    input  logic [ROBIDX_W-1:0]         io_snpt_enqRobIdx,
    input  logic                        io_snpt_snptDeq,
    input  logic                        io_snpt_useSnpt,
    input  logic [$clog2(SNPT_NUM)-1:0] io_snpt_snptSelect,
    input  logic [SNPT_NUM-1:0]         io_snpt_flushVec,
    output logic                        o_wfi_sleeping,
    output logic                        o_wfi_blockCommit,
    output logic                        o_wfi_wakeup,
    output logic                        o_wfi_done,
    output logic [SNPT_NUM-1:0]         o_snpt_valid,
    output logic                        o_snpt_full,
    output logic                        o_snpt_restore_valid,
    output logic [ROBIDX_W-1:0]         o_snpt_restore_robIdx
);

    localparam int PTR_W = $clog2(SNPT_NUM);
    localparam logic [TMO_W-1:0] TMO_LAST = WFI_TMO - TMO_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        WAIT  = 2'd2,
        WAKE  = 2'd3
    } wfi_state_t;

    wfi_state_t       state, state_nxt;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
    logic             done_q, done_nxt;
    logic             wake_evt, tmo_hit, drained;

    assign wake_evt = io_csr_intrBitSet | io_csr_wfiEvent;
    assign drained  = io_wfi_safeFromMem & io_wfi_safeFromFrontend;
    assign tmo_hit  = (WFI_TMO != '0) && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tmo_cnt <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_cnt_nxt;
            done_q  <= done_nxt;
        end
    end

    // Critical error beats every wake source; a wake beats the drained condition.
    always_comb begin
        state_nxt   = state;
        tmo_cnt_nxt = tmo_cnt;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (io_wfi_req) begin
                    if (io_wfi_enable && !io_csr_criticalErrorState) state_nxt = DRAIN;
                    else                                            done_nxt  = 1'b1;
                end
            end
            DRAIN: begin
                if (io_csr_criticalErrorState) state_nxt = IDLE;
                else if (wake_evt)             state_nxt = WAKE;
                else if (drained) begin
                    state_nxt   = WAIT;
                    tmo_cnt_nxt = '0;
                end
            end
            WAIT: begin
                if (tmo_cnt != '1) tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
                if (io_csr_criticalErrorState)  state_nxt = IDLE;
                else if (wake_evt || tmo_hit)   state_nxt = WAKE;
            end
            WAKE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign o_wfi_sleeping    = (state == WAIT);
    assign o_wfi_blockCommit = (state == DRAIN) || (state == WAIT);
    assign o_wfi_wakeup      = (state == WAKE);
    assign o_wfi_done        = done_q;

    logic [SNPT_NUM-1:0] valid, valid_nxt, younger;
    logic [ROBIDX_W-1:0] rob_idx [SNPT_NUM];
    logic [PTR_W-1:0]    enq_ptr, deq_ptr, enq_ptr_nxt, deq_ptr_nxt, age_sel;
    logic                sel_ok, deq_fire, enq_fire;
    logic                restore_valid;
    logic [ROBIDX_W-1:0] restore_idx;

    assign sel_ok   = io_snpt_useSnpt & valid[io_snpt_snptSelect];
    assign deq_fire = io_snpt_snptDeq & valid[deq_ptr];
    assign enq_fire = io_snpt_enq & (~valid[enq_ptr] | (deq_fire & (deq_ptr == enq_ptr)));
    assign age_sel  = io_snpt_snptSelect - deq_ptr;

    // Age is distance from the oldest pointer; anything older-than-select survives a restore.
    always_comb begin
        logic [PTR_W-1:0] age_i;
        age_i   = '0;
        younger = '0;
        for (int i = 0; i < SNPT_NUM; i++) begin
            age_i      = PTR_W'(i) - deq_ptr;
            younger[i] = (age_i > age_sel);
        end
    end

    always_comb begin
        valid_nxt   = valid & ~io_snpt_flushVec;
        enq_ptr_nxt = enq_ptr;
        deq_ptr_nxt = deq_ptr;
        if (sel_ok) begin
            valid_nxt   = valid_nxt & ~younger;
            enq_ptr_nxt = io_snpt_snptSelect + PTR_W'(1);
        end else begin
            if (deq_fire) begin
                valid_nxt[deq_ptr] = 1'b0;
                deq_ptr_nxt        = deq_ptr + PTR_W'(1);
            end else if (!valid[deq_ptr] && (deq_ptr != enq_ptr)) begin
                deq_ptr_nxt = deq_ptr + PTR_W'(1);
            end
            if (enq_fire) begin
                valid_nxt[enq_ptr] = 1'b1;
                enq_ptr_nxt        = enq_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid         <= '0;
            enq_ptr       <= '0;
            deq_ptr       <= '0;
            restore_valid <= 1'b0;
            restore_idx   <= '0;
        end else begin
            valid         <= valid_nxt;
            enq_ptr       <= enq_ptr_nxt;
            deq_ptr       <= deq_ptr_nxt;
            restore_valid <= sel_ok;
            if (sel_ok) restore_idx <= rob_idx[io_snpt_snptSelect];
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire && !sel_ok) rob_idx[enq_ptr] <= io_snpt_enqRobIdx;
    end

    assign o_snpt_valid          = valid;
    assign o_snpt_full           = &valid;
    assign o_snpt_restore_valid  = restore_valid;
    assign o_snpt_restore_robIdx = restore_idx;

endmodule

// File: tb/tb_rob_wfi_snpt_ctrl.sv
// Testbench for rob_wfi_snpt_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_rob_wfi_snpt_ctrl;

    localparam int SN = 4;
    localparam int RW = 8;
    localparam int TB_TMO = 16;

    localparam int PH_REST  = 10;
    localparam int PH_DRAIN = 11;
    localparam int PH_SLEEP = 12;
    localparam int PH_WAKE  = 13;

    logic clk = 1'b0;
    logic rst;
    logic wfi_req, wfi_en, safe_mem, safe_fe, intr, evt, crit;
    logic enq, deq, use_s;
    logic [RW-1:0] enq_idx;
    logic [1:0] sel;
    logic [SN-1:0] flush;
    logic sleeping, block, wakeup, done, full, rvalid;
    logic [SN-1:0] svalid;
    logic [RW-1:0] ridx;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    int m_ph;
    int m_cnt;
    bit m_done;
    bit m_v [SN];
    int m_rob [SN];
    int m_enq, m_deq;
    bit m_rv;
    int m_ridx;

    always #5 clk = ~clk;

    rob_wfi_snpt_ctrl #(
        .SNPT_NUM(SN), .ROBIDX_W(RW), .TMO_W(16), .WFI_TMO(16'(TB_TMO))
    ) dut (
        .clk(clk), .rst(rst),
        .io_wfi_req(wfi_req), .io_wfi_enable(wfi_en),
        .io_wfi_safeFromMem(safe_mem), .io_wfi_safeFromFrontend(safe_fe),
        .io_csr_intrBitSet(intr), .io_csr_wfiEvent(evt),
        .io_csr_criticalErrorState(crit),
        .io_snpt_enq(enq), .io_snpt_enqRobIdx(enq_idx),
        .io_snpt_snptDeq(deq), .io_snpt_useSnpt(use_s),
        .io_snpt_snptSelect(sel), .io_snpt_flushVec(flush),
        .o_wfi_sleeping(sleeping), .o_wfi_blockCommit(block),
        .o_wfi_wakeup(wakeup), .o_wfi_done(done),
        .o_snpt_valid(svalid), .o_snpt_full(full),
        .o_snpt_restore_valid(rvalid), .o_snpt_restore_robIdx(ridx)
    );

    function automatic logic [SN-1:0] m_vec();
        logic [SN-1:0] r;
        for (int i = 0; i < SN; i++) r[i] = m_v[i];
        return r;
    endfunction

    function automatic int age(input int slot);
        return (slot - m_deq + SN) % SN;
    endfunction

    task automatic model_step();
        int nph, ncnt;
        bit nv [SN];
        bit sel_ok, deq_ok, enq_ok;
        if (rst) begin
            m_ph = PH_REST; m_cnt = 0; m_done = 0;
            for (int i = 0; i < SN; i++) m_v[i] = 0;
            m_enq = 0; m_deq = 0; m_rv = 0; m_ridx = 0;
            return;
        end
        nph = m_ph; ncnt = m_cnt;
        m_done = (m_ph == PH_REST) && wfi_req && (!wfi_en || crit);
        if (m_ph == PH_REST) begin
            if (wfi_req && wfi_en && !crit) nph = PH_DRAIN;
        end else if (m_ph == PH_DRAIN) begin
            if (crit) nph = PH_REST;
            else if (intr || evt) nph = PH_WAKE;
            else if (safe_mem && safe_fe) begin nph = PH_SLEEP; ncnt = 0; end
        end else if (m_ph == PH_SLEEP) begin
            ncnt = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
            if (crit) nph = PH_REST;
            else if (intr || evt || (TB_TMO != 0 && m_cnt == TB_TMO - 1)) nph = PH_WAKE;
        end else begin
            nph = PH_REST;
        end
        m_ph = nph; m_cnt = ncnt;

        sel_ok = use_s && m_v[sel];
        deq_ok = deq && m_v[m_deq];
        enq_ok = enq && (!m_v[m_enq] || (deq_ok && m_deq == m_enq));
        for (int i = 0; i < SN; i++) nv[i] = m_v[i] && !flush[i];
        if (sel_ok) begin
            for (int i = 0; i < SN; i++) if (age(i) > age(int'(sel))) nv[i] = 0;
            m_rv = 1; m_ridx = m_rob[sel];
            m_enq = (int'(sel) + 1) % SN;
        end else begin
            m_rv = 0;
            if (deq_ok) begin nv[m_deq] = 0; m_deq = (m_deq + 1) % SN; end
            else if (!m_v[m_deq] && m_deq != m_enq) m_deq = (m_deq + 1) % SN;
            if (enq_ok) begin
                nv[m_enq] = 1; m_rob[m_enq] = int'(enq_idx);
                m_enq = (m_enq + 1) % SN;
            end
        end
        for (int i = 0; i < SN; i++) m_v[i] = nv[i];
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wfi_req = 0; wfi_en = 1; safe_mem = 0; safe_fe = 0; intr = 0; evt = 0; crit = 0;
        enq = 0; deq = 0; use_s = 0; enq_idx = '0; sel = '0; flush = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1; tick(); rst = 0;
    endtask

    task automatic test_reset();
        logic [RW+SN+7:0] outs;
        do_reset();
        outs = {sleeping, block, wakeup, done, svalid, full, rvalid, ridx, 2'b00};
        checks++;
        if (outs !== '0) begin failures++; $display("FAIL reset_outputs got=%0h exp=0", outs); end
        // Build up state, then reset mid-operation
        wfi_req = 1; enq = 1; enq_idx = 8'h33; tick();
        wfi_req = 0; tick();
        enq = 0; use_s = 1; sel = 0; tick();
        use_s = 0;
        checks++;
        if (block !== 1'b1 || svalid !== 4'b0001 || rvalid !== 1'b1) begin
            failures++; $display("FAIL pre_reset_state got=%b%b%b exp=1 0001 1", block, svalid, rvalid);
        end
        rst = 1; tick(); rst = 0;
        outs = {sleeping, block, wakeup, done, svalid, full, rvalid, ridx, 2'b00};
        checks++;
        if (outs !== '0) begin failures++; $display("FAIL reset_midop got=%0h exp=0", outs); end
    endtask

    task automatic test_wfi_sleep();
        int nblk = 0, nslp = 0, nwk = 0, wk_at = -1;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            wfi_req = (k == 0);
            safe_mem = (k >= 3); safe_fe = (k >= 3);
            intr = (k == 8);
            tick();
            if (block) nblk++;
            if (sleeping) nslp++;
            if (wakeup) begin nwk++; wk_at = k; end
        end
        checks++;
        if (nblk != 8) begin failures++; $display("FAIL sleep_block_cycles got=%0d exp=8", nblk); end
        checks++;
        if (nslp != 5) begin failures++; $display("FAIL sleep_wait_cycles got=%0d exp=5", nslp); end
        checks++;
        if (nwk != 1 || wk_at != 8) begin
            failures++; $display("FAIL sleep_wakeup got=%0d@%0d exp=1@8", nwk, wk_at);
        end
    endtask

    task automatic test_wfi_disabled();
        int ndone = 0, nblk = 0;
        do_reset();
        wfi_en = 0;
        for (int k = 0; k < 5; k++) begin
            wfi_req = (k == 0);
            safe_mem = 1; safe_fe = 1;
            tick();
            if (k == 0) begin
                checks++;
                if (done !== 1'b1) begin failures++; $display("FAIL disabled_done got=%b exp=1", done); end
            end
            if (done) ndone++;
            if (block || sleeping) nblk++;
        end
        checks++;
        if (ndone != 1 || nblk != 0) begin
            failures++; $display("FAIL disabled_pulse got=done%0d blk%0d exp=done1 blk0", ndone, nblk);
        end
        wfi_en = 1; crit = 1; wfi_req = 1; tick();
        wfi_req = 0; crit = 0;
        checks++;
        if (done !== 1'b1 || block !== 1'b0) begin
            failures++; $display("FAIL crit_req_done got=%b%b exp=10", done, block);
        end
    endtask

    task automatic test_wfi_timeout();
        int wk_at = -1, nslp = 0;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            wfi_req = (k == 0);
            safe_mem = 1; safe_fe = 1;
            tick();
            if (sleeping) nslp++;
            if (wakeup && wk_at < 0) wk_at = k;
        end
        checks++;
        if (wk_at != 17 || nslp != 16) begin
            failures++; $display("FAIL timeout_wakeup got=at%0d wait%0d exp=at17 wait16", wk_at, nslp);
        end
    endtask

    task automatic test_wfi_crit();
        int nwk = 0;
        do_reset();
        wfi_req = 1; tick();
        wfi_req = 0; safe_mem = 1; safe_fe = 1; tick();
        tick();
        checks++;
        if (sleeping !== 1'b1) begin failures++; $display("FAIL crit_enter_wait got=%b exp=1", sleeping); end
        crit = 1; intr = 1; tick();
        crit = 0; intr = 0;
        checks++;
        if ({sleeping, block, wakeup} !== 3'b000) begin
            failures++; $display("FAIL crit_in_wait got=%b exp=000", {sleeping, block, wakeup});
        end
        for (int k = 0; k < 4; k++) begin tick(); if (wakeup) nwk++; end
        checks++;
        if (nwk != 0) begin failures++; $display("FAIL crit_no_wakeup got=%0d exp=0", nwk); end
        // Wake beats drained in the same DRAIN cycle
        wfi_req = 1; safe_mem = 0; safe_fe = 0; tick();
        wfi_req = 0; safe_mem = 1; safe_fe = 1; evt = 1; tick();
        evt = 0;
        checks++;
        if ({sleeping, wakeup} !== 2'b01) begin
            failures++; $display("FAIL wake_over_drain got=%b exp=01", {sleeping, wakeup});
        end
    endtask

    task automatic test_snpt_fill();
        do_reset();
        for (int k = 0; k < 4; k++) begin enq = 1; enq_idx = 8'((k + 1) * 10); tick(); end
        checks++;
        if (svalid !== 4'b1111 || full !== 1'b1) begin
            failures++; $display("FAIL fill_full got=%b%b exp=1111 1", svalid, full);
        end
        enq_idx = 8'd99; tick();
        enq = 0; use_s = 1; sel = 0; tick();
        use_s = 0;
        checks++;
        if (ridx !== 8'd10) begin failures++; $display("FAIL fifth_enq_dropped got=%0d exp=10", ridx); end
        // Restore to slot 0 trimmed younger entries; refill before the deq+enq case
        do_reset();
        for (int k = 0; k < 4; k++) begin enq = 1; enq_idx = 8'((k + 1) * 10); tick(); end
        deq = 1; enq = 1; enq_idx = 8'd50; tick();
        deq = 0; enq = 0;
        checks++;
        if (svalid !== 4'b1111) begin failures++; $display("FAIL deq_enq_full got=%b exp=1111", svalid); end
        use_s = 1; sel = 0; tick();
        use_s = 0;
        checks++;
        if (rvalid !== 1'b1 || ridx !== 8'd50) begin
            failures++; $display("FAIL deq_enq_slot0 got=%b/%0d exp=1/50", rvalid, ridx);
        end
    endtask

    task automatic test_snpt_restore();
        do_reset();
        for (int k = 0; k < 4; k++) begin enq = 1; enq_idx = 8'((k + 1) * 10); tick(); end
        enq = 1; deq = 1; enq_idx = 8'd77; use_s = 1; sel = 1; tick();
        enq = 0; deq = 0; use_s = 0;
        checks++;
        if (rvalid !== 1'b1 || ridx !== 8'd20 || svalid !== 4'b0011) begin
            failures++; $display("FAIL restore_sel1 got=%b/%0d/%b exp=1/20/0011", rvalid, ridx, svalid);
        end
        enq = 1; enq_idx = 8'd99; tick();
        enq = 0;
        checks++;
        if (svalid !== 4'b0111 || rvalid !== 1'b0) begin
            failures++; $display("FAIL restore_next_enq got=%b/%b exp=0111/0", svalid, rvalid);
        end
        use_s = 1; sel = 3; tick();
        use_s = 0;
        checks++;
        if (rvalid !== 1'b0 || svalid !== 4'b0111 || ridx !== 8'd20) begin
            failures++; $display("FAIL restore_invalid got=%b/%b/%0d exp=0/0111/20", rvalid, svalid, ridx);
        end
    endtask

    task automatic test_snpt_flush();
        do_reset();
        flush = 4'b0001; enq = 1; enq_idx = 8'd5; tick();
        flush = '0; enq = 0;
        checks++;
        if (svalid !== 4'b0001) begin failures++; $display("FAIL flush_with_enq got=%b exp=0001", svalid); end
        do_reset();
        for (int k = 0; k < 3; k++) begin enq = 1; enq_idx = 8'(k + 1); tick(); end
        enq = 0; flush = 4'b0001; tick();
        flush = '0;
        checks++;
        if (svalid !== 4'b0110) begin failures++; $display("FAIL flush_clear got=%b exp=0110", svalid); end
        deq = 1; tick();
        checks++;
        if (svalid !== 4'b0110) begin failures++; $display("FAIL deq_on_hole got=%b exp=0110", svalid); end
        tick();
        deq = 0;
        checks++;
        if (svalid !== 4'b0100) begin failures++; $display("FAIL deq_after_skip got=%b exp=0100", svalid); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 199) == 0);
            wfi_req  = ($urandom_range(0, 19) == 0);
            wfi_en   = ($urandom_range(0, 4) != 0);
            safe_mem = ($urandom_range(0, 2) != 0);
            safe_fe  = ($urandom_range(0, 2) != 0);
            intr     = ($urandom_range(0, 29) == 0);
            evt      = ($urandom_range(0, 29) == 0);
            crit     = ($urandom_range(0, 59) == 0);
            enq      = $urandom_range(0, 1) == 1;
            enq_idx  = 8'($urandom);
            deq      = ($urandom_range(0, 2) == 0);
            use_s    = ($urandom_range(0, 14) == 0);
            sel      = 2'($urandom_range(0, 3));
            flush    = ($urandom_range(0, 14) == 0) ? 4'($urandom) : 4'b0000;
            tick();
            checks++;
            if ({sleeping, block, wakeup, done} !==
                {m_ph == PH_SLEEP, m_ph == PH_DRAIN || m_ph == PH_SLEEP, m_ph == PH_WAKE, m_done}) begin
                failures++;
                $display("FAIL rand_wfi cyc=%0d got=%b exp_phase=%0d done=%b", n,
                         {sleeping, block, wakeup, done}, m_ph, m_done);
            end
            checks++;
            if (svalid !== m_vec() || full !== (&m_vec()) || rvalid !== m_rv ||
                (m_rv && ridx !== 8'(m_ridx))) begin
                failures++;
                $display("FAIL rand_snpt cyc=%0d got=%b/%b/%b/%0d exp=%b/%b/%b/%0d", n,
                         svalid, full, rvalid, ridx, m_vec(), &m_vec(), m_rv, m_ridx);
            end
        end
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_wfi_sleep();
        test_wfi_disabled();
        test_wfi_timeout();
        test_wfi_crit();
        test_snpt_fill();
        test_snpt_restore();
        test_snpt_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
